// File: rtl/pipe_power_sequencer_pkg.sv
// rtl/pipe_power_sequencer_pkg.sv - shared encodings, FSM states and transition legality for the PIPE power sequencer
package pipe_pwr_pkg;

    typedef enum logic [1:0] {
        PWR_P0  = 2'b00,
        PWR_P0S = 2'b01,
        PWR_P1  = 2'b10,
        PWR_P2  = 2'b11
    } pwr_state_e;

    typedef enum logic [1:0] {
        STAT_OK      = 2'b00,
        STAT_ILLEGAL = 2'b01,
        STAT_TIMEOUT = 2'b10
    } done_status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHANGE,
        S_DETECT,
        S_RESP
    } seq_state_e;

    // Only neighbouring states in the PIPE power ladder may be reached directly
    function automatic logic is_legal(pwr_state_e cur, pwr_state_e tgt);
        case ({cur, tgt})
            {PWR_P0, PWR_P0S}, {PWR_P0S, PWR_P0},
            {PWR_P0, PWR_P1},  {PWR_P1, PWR_P0},
            {PWR_P1, PWR_P2},  {PWR_P2, PWR_P1}: return 1'b1;
            default:                            return cur == tgt;
        endcase
    endfunction

endpackage

// File: rtl/pipe_power_sequencer_if.sv
// rtl/pipe_power_sequencer_if.sv - MAC request/response and PHY power-manager signals of the sequencer
interface pipe_power_sequencer_if;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [1:0] REQ_STATE;
    logic       REQ_DETECT;
    logic       DONE;
    logic [1:0] DONE_STATUS;
    logic       DET_PRESENT;
    logic [1:0] CUR_STATE;
    logic [1:0] PWRDDWN;
    logic       RXDET_LOOPB;
    logic       PHYSTATUS;
    logic       RXDET;

    // Environment side: MAC requester plus PHY power manager
    modport master (
        output REQ_VALID, REQ_STATE, REQ_DETECT, PHYSTATUS, RXDET,
        input  REQ_READY, DONE, DONE_STATUS, DET_PRESENT, CUR_STATE, PWRDDWN, RXDET_LOOPB
    );

    // Sequencer side
    modport slave (
        input  REQ_VALID, REQ_STATE, REQ_DETECT, PHYSTATUS, RXDET,
        output REQ_READY, DONE, DONE_STATUS, DET_PRESENT, CUR_STATE, PWRDDWN, RXDET_LOOPB
    );
endinterface

// File: rtl/pipe_power_sequencer_timer.sv
// rtl/pipe_power_sequencer_timer.sv - PHYSTATUS wait timeout counter (pwrseq_timer)
module pwrseq_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    // Count wait cycles; the value during the k-th wait cycle is k-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    // Terminal count is the TIMEOUT_CYCLES-th wait cycle
    assign expired = enable && (count == LAST);
endmodule

// File: rtl/pipe_power_sequencer.sv
// rtl/pipe_power_sequencer.sv - PIPE PHY power-state / receiver-detect sequencer; PWRSEQ_TIMEOUT_EN adds the PHYSTATUS timeout
module pipe_power_sequencer
    import pipe_pwr_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input logic                   REFCLK,
    input logic                   RESET,
    pipe_power_sequencer_if.slave bus
);
    seq_state_e   state;
    pwr_state_e   cur_q;
    pwr_state_e   pwr_q;
    done_status_e status_q;
    logic         ready_q;
    logic         done_q;
    logic         det_q;
    logic         loopb_q;
    logic         waiting;
    logic         timeout_hit;
    pwr_state_e   tgt;

    assign tgt     = pwr_state_e'(bus.REQ_STATE);
    assign waiting = (state == S_CHANGE) || (state == S_DETECT);

`ifdef PWRSEQ_TIMEOUT_EN
    pwrseq_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (REFCLK),
        .rst    (RESET),
        .clear  (!waiting),
        .enable (waiting),
        .expired(timeout_hit)
    );
`else
    // Without the timer the sequencer waits for PHYSTATUS or RESET forever
    assign timeout_hit = 1'b0;
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

    // Request sequencing FSM with all outputs registered
    always_ff @(posedge REFCLK or posedge RESET) begin
        if (RESET) begin
            state    <= S_IDLE;
            cur_q    <= PWR_P1;
            pwr_q    <= PWR_P1;
            status_q <= STAT_OK;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            det_q    <= 1'b0;
            loopb_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.REQ_VALID) begin
                        ready_q <= 1'b0;
                        if (bus.REQ_DETECT) begin
                            if (cur_q == PWR_P1) begin
                                loopb_q <= 1'b1;
                                state   <= S_DETECT;
                            end else begin
                                done_q   <= 1'b1;
                                status_q <= STAT_ILLEGAL;
                                state    <= S_RESP;
                            end
                        end else if (tgt == cur_q) begin
                            done_q   <= 1'b1;
                            status_q <= STAT_OK;
                            state    <= S_RESP;
                        end else if (is_legal(cur_q, tgt)) begin
                            pwr_q <= tgt;
                            state <= S_CHANGE;
                        end else begin
                            done_q   <= 1'b1;
                            status_q <= STAT_ILLEGAL;
                            state    <= S_RESP;
                        end
                    end
                end
                S_CHANGE: begin
                    if (bus.PHYSTATUS) begin
                        cur_q    <= pwr_q;
                        done_q   <= 1'b1;
                        status_q <= STAT_OK;
                        state    <= S_RESP;
                    end else if (timeout_hit) begin
                        pwr_q    <= cur_q;
                        done_q   <= 1'b1;
                        status_q <= STAT_TIMEOUT;
                        state    <= S_RESP;
                    end
                end
                S_DETECT: begin
                    if (bus.PHYSTATUS) begin
                        det_q    <= bus.RXDET;
                        loopb_q  <= 1'b0;
                        done_q   <= 1'b1;
                        status_q <= STAT_OK;
                        state    <= S_RESP;
                    end else if (timeout_hit) begin
                        loopb_q  <= 1'b0;
                        done_q   <= 1'b1;
                        status_q <= STAT_TIMEOUT;
                        state    <= S_RESP;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.REQ_READY   = ready_q;
    assign bus.DONE        = done_q;
    assign bus.DONE_STATUS = status_q;
    assign bus.DET_PRESENT = det_q;
    assign bus.CUR_STATE   = cur_q;
    assign bus.PWRDDWN     = pwr_q;
    assign bus.RXDET_LOOPB = loopb_q;
endmodule

// File: tb/tb_pipe_power_sequencer.sv
// tb/tb_pipe_power_sequencer.sv - self-checking bench for pipe_power_sequencer
module tb_pipe_power_sequencer;
    localparam int TO = 8;

    logic REFCLK = 1'b0;
    logic RESET  = 1'b1;

    pipe_power_sequencer_if bus();

    pipe_power_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .REFCLK(REFCLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 REFCLK = ~REFCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction-level view of the sequencer
    bit legal [4][4];
    int m_ready = 1, m_done = 0, m_status = 0, m_det = 0;
    int m_cur = 2, m_pwr = 2, m_loopb = 0;
    int m_wait = 0;   // 0 none, 1 state change pending, 2 detect pending
    int m_cnt = 0;

    initial begin
        foreach (legal[i, j]) legal[i][j] = 1'b0;
        legal[0][1] = 1'b1; legal[1][0] = 1'b1;
        legal[0][2] = 1'b1; legal[2][0] = 1'b1;
        legal[2][3] = 1'b1; legal[3][2] = 1'b1;
    end

    always @(posedge REFCLK or posedge RESET) begin
        if (RESET) begin
            m_ready <= 1; m_done <= 0; m_status <= 0; m_det <= 0;
            m_cur <= 2; m_pwr <= 2; m_loopb <= 0; m_wait <= 0; m_cnt <= 0;
        end else if (m_done != 0) begin
            m_done  <= 0;
            m_ready <= 1;
        end else if (m_wait != 0) begin
            m_cnt <= m_cnt + 1;
            if (bus.PHYSTATUS) begin
                if (m_wait == 1) m_cur <= m_pwr;
                else begin
                    m_det   <= int'(bus.RXDET);
                    m_loopb <= 0;
                end
                m_status <= 0; m_done <= 1; m_wait <= 0;
            end
`ifdef PWRSEQ_TIMEOUT_EN
            else if (m_cnt + 1 == TO) begin
                m_pwr <= m_cur; m_loopb <= 0;
                m_status <= 2; m_done <= 1; m_wait <= 0;
            end
`endif
        end else if (m_ready != 0 && bus.REQ_VALID) begin
            m_ready <= 0;
            m_cnt   <= 0;
            if (bus.REQ_DETECT) begin
                if (m_cur == 2) begin m_loopb <= 1; m_wait <= 2; end
                else begin m_done <= 1; m_status <= 1; end
            end else if (int'(bus.REQ_STATE) == m_cur) begin
                m_done <= 1; m_status <= 0;
            end else if (legal[m_cur][bus.REQ_STATE]) begin
                m_pwr <= int'(bus.REQ_STATE); m_wait <= 1;
            end else begin
                m_done <= 1; m_status <= 1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge REFCLK) begin
        if (!RESET) begin
            chk("ready",   bus.REQ_READY,   m_ready);
            chk("done",    bus.DONE,        m_done);
            if (m_done != 0) chk("status", bus.DONE_STATUS, m_status);
            chk("det",     bus.DET_PRESENT, m_det);
            chk("cur",     bus.CUR_STATE,   m_cur);
            chk("pwrddwn", bus.PWRDDWN,     m_pwr);
            chk("loopb",   bus.RXDET_LOOPB, m_loopb);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge REFCLK);
    endtask

    task automatic req(input logic det, input logic [1:0] st);
        bus.REQ_VALID = 1'b1; bus.REQ_DETECT = det; bus.REQ_STATE = st;
        @(negedge REFCLK);
        bus.REQ_VALID = 1'b0; bus.REQ_DETECT = 1'b0;
    endtask

    task automatic pulse_phy(input logic rx);
        bus.PHYSTATUS = 1'b1; bus.RXDET = rx;
        @(negedge REFCLK);
        bus.PHYSTATUS = 1'b0; bus.RXDET = 1'b0;
    endtask

    initial begin
        bus.REQ_VALID = 0; bus.REQ_STATE = 0; bus.REQ_DETECT = 0;
        bus.PHYSTATUS = 0; bus.RXDET = 0;
        cyc(2);
        RESET = 1'b0;
        chk("rst_pwrddwn", bus.PWRDDWN, 2);
        chk("rst_cur",     bus.CUR_STATE, 2);
        chk("rst_loopb",   bus.RXDET_LOOPB, 0);
        chk("rst_ready",   bus.REQ_READY, 1);
        chk("rst_done",    bus.DONE, 0);
        chk("rst_status",  bus.DONE_STATUS, 0);
        chk("rst_det",     bus.DET_PRESENT, 0);
        cyc(1);

        // P1 -> P0 with PHYSTATUS five cycles after accept
        req(1'b0, 2'b00);
        chk("p0_pwrddwn", bus.PWRDDWN, 0);
        chk("p0_ready", bus.REQ_READY, 0);
        cyc(4);
        pulse_phy(1'b0);
        chk("p0_done", bus.DONE, 1);
        chk("p0_status", bus.DONE_STATUS, 0);
        chk("p0_cur", bus.CUR_STATE, 0);
        cyc(1);
        chk("p0_ready_back", bus.REQ_READY, 1);

        // P0 -> P2 is illegal
        req(1'b0, 2'b11);
        chk("ill_done", bus.DONE, 1);
        chk("ill_status", bus.DONE_STATUS, 1);
        chk("ill_pwrddwn", bus.PWRDDWN, 0);
        cyc(1);

        // back to P1, then receiver detect
        req(1'b0, 2'b10); cyc(2); pulse_phy(1'b0);
        chk("to_p1_cur", bus.CUR_STATE, 2);
        cyc(1);
        req(1'b1, 2'b00);
        chk("det_loopb", bus.RXDET_LOOPB, 1);
        cyc(2);
        chk("det_loopb_hold", bus.RXDET_LOOPB, 1);
        pulse_phy(1'b1);
        chk("det_done", bus.DONE, 1);
        chk("det_status", bus.DONE_STATUS, 0);
        chk("det_present", bus.DET_PRESENT, 1);
        chk("det_loopb_off", bus.RXDET_LOOPB, 0);
        cyc(1);

        // detect from P0 is illegal
        req(1'b0, 2'b00); pulse_phy(1'b0); cyc(1);
        req(1'b1, 2'b00);
        chk("det_p0_done", bus.DONE, 1);
        chk("det_p0_status", bus.DONE_STATUS, 1);
        chk("det_p0_loopb", bus.RXDET_LOOPB, 0);
        cyc(1);
        req(1'b0, 2'b10); pulse_phy(1'b0); cyc(1);

`ifdef PWRSEQ_TIMEOUT_EN
        // P1 -> P2 with no PHYSTATUS
        req(1'b0, 2'b11);
        cyc(7);
        chk("to_not_yet", bus.DONE, 0);
        cyc(1);
        chk("to_done", bus.DONE, 1);
        chk("to_status", bus.DONE_STATUS, 2);
        chk("to_pwrddwn", bus.PWRDDWN, 2);
        chk("to_cur", bus.CUR_STATE, 2);
        cyc(1);
        // PHYSTATUS on the terminal-count cycle wins
        req(1'b0, 2'b11);
        cyc(7);
        pulse_phy(1'b0);
        chk("tc_done", bus.DONE, 1);
        chk("tc_status", bus.DONE_STATUS, 0);
        chk("tc_cur", bus.CUR_STATE, 3);
        cyc(1);
`else
        // without the timer the sequencer keeps waiting
        req(1'b0, 2'b11);
        cyc(30);
        chk("wait_ready", bus.REQ_READY, 0);
        chk("wait_done", bus.DONE, 0);
        chk("wait_pwrddwn", bus.PWRDDWN, 3);
        pulse_phy(1'b0);
        chk("wait_done_late", bus.DONE, 1);
        chk("wait_status", bus.DONE_STATUS, 0);
        chk("wait_cur", bus.CUR_STATE, 3);
        cyc(1);
`endif

        // asynchronous reset while in CHANGE (P2 -> P1)
        req(1'b0, 2'b10);
        cyc(1);
        #2 RESET = 1'b1;
        #1;
        chk("ar_pwrddwn", bus.PWRDDWN, 2);
        chk("ar_cur", bus.CUR_STATE, 2);
        chk("ar_ready", bus.REQ_READY, 1);
        chk("ar_done", bus.DONE, 0);
        chk("ar_loopb", bus.RXDET_LOOPB, 0);
        @(negedge REFCLK);
        RESET = 1'b0;
        cyc(1);
        chk("ar_no_done", bus.DONE, 0);
        req(1'b0, 2'b00); pulse_phy(1'b0);
        chk("ar_after_done", bus.DONE, 1);
        chk("ar_after_cur", bus.CUR_STATE, 0);
        cyc(1);

        // randomized traffic
        repeat (3000) begin
            bus.REQ_VALID  = 1'($urandom_range(0, 1));
            bus.REQ_DETECT = ($urandom_range(0, 3) == 0);
            bus.REQ_STATE  = 2'($urandom_range(0, 3));
            bus.PHYSTATUS  = ($urandom_range(0, 9) == 0);
            bus.RXDET      = 1'($urandom_range(0, 1));
            RESET          = ($urandom_range(0, 499) == 0);
            @(negedge REFCLK);
        end
        RESET = 1'b0;
        bus.REQ_VALID = 0; bus.REQ_DETECT = 0; bus.PHYSTATUS = 0; bus.RXDET = 0;
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_power_sequencer.md
# pipe_power_sequencer

Sequences the PHY power manager on behalf of the MAC. Accepts one power-state-change or receiver-detect request at a time and drives PWRDDWN / RXDET_LOOPB toward the power manager. Waits for the PHYSTATUS completion pulse, then reports the result to the MAC with a one-cycle DONE strobe. Rejects PIPE-illegal transitions without touching the PHY.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1023: cycles to wait for PHYSTATUS before aborting (≥1).

Ports:
- REFCLK  in  1  clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  MAC request valid.
- REQ_READY  out  1  sequencer can accept a request.
- REQ_STATE  in  2  target power state (P0=00, P0s=01, P1=10, P2=11); ignored when REQ_DETECT=1.
- REQ_DETECT  in  1  request receiver detection instead of a state change.
- DONE  out  1  one-cycle completion strobe.
- DONE_STATUS  out  2  00 OK, 01 ILLEGAL, 10 TIMEOUT; valid only with DONE.
- DET_PRESENT  out  1  receiver-detect result; valid with DONE after a detect request.
- CUR_STATE  out  2  last confirmed power state.
- PWRDDWN  out  2  power state driven to the power manager.
- RXDET_LOOPB  out  1  receiver-detect request to the power manager.
- PHYSTATUS  in  1  completion pulse from the power manager.
- RXDET  in  1  detect result from the power manager; sampled with PHYSTATUS.

## Operation
- Reset values: PWRDDWN=P1, CUR_STATE=P1, RXDET_LOOPB=0, REQ_READY=1, DONE=0, DONE_STATUS=00, DET_PRESENT=0. FSM enters IDLE.
- FSM states:
  - IDLE: REQ_READY=1. A request is accepted on REQ_VALID & REQ_READY.
  - CHANGE: PWRDDWN = target; wait for PHYSTATUS.
  - DETECT: RXDET_LOOPB=1; wait for PHYSTATUS.
  - RESP: DONE=1 for one cycle, then IDLE.
- Legal transitions: P0↔P0s, P0↔P1, P1↔P2. All others (P0s→P1/P2, P2→P0/P0s, P1→P0s) go IDLE→RESP with ILLEGAL. PWRDDWN and CUR_STATE are unchanged.
- Same-state request: IDLE→RESP with OK. No PHY activity.
- Detect requests are legal only when CUR_STATE=P1; otherwise the result is ILLEGAL. On PHYSTATUS in DETECT: DET_PRESENT←RXDET, RXDET_LOOPB←0, status OK.
- On PHYSTATUS in CHANGE: CUR_STATE←PWRDDWN, status OK.
- PHYSTATUS in IDLE or RESP is ignored.
- Timeout: the counter clears on entry to CHANGE/DETECT and increments every cycle there. On reaching TIMEOUT_CYCLES with no PHYSTATUS, the FSM goes to RESP with TIMEOUT. PWRDDWN reverts to CUR_STATE, RXDET_LOOPB←0, and CUR_STATE is unchanged.
- PHYSTATUS in the same cycle as the timeout terminal count: PHYSTATUS wins (OK).
- Reset asserted mid-operation: immediate return to reset values. No DONE is issued and the pending request is dropped.
- DET_PRESENT holds its value until the next detect completion.

## Timing
- Request accepted at edge N: PWRDDWN (or RXDET_LOOPB) updates at N+1 and REQ_READY=0 from N+1.
- PHYSTATUS is sampled from the first CHANGE/DETECT cycle. If it is high during cycle M, DONE/CUR_STATE/DET_PRESENT update at M+1 and REQ_READY returns at M+2.
- Rejected or same-state request: DONE at N+1, REQ_READY at N+2.
- Minimum request-to-request spacing: 2 cycles.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- PWRSEQ_TIMEOUT_EN defined: timeout counter present; TIMEOUT status is reachable.
- Not defined: no counter. CHANGE/DETECT wait indefinitely for PHYSTATUS (or RESET), and status 10 is never produced.

## Structure
- Package pipe_pwr_pkg holds:
  - power-state encodings P0/P0s/P1/P2;
  - DONE_STATUS codes;
  - FSM state enum;
  - the legality function (current, target) → legal.
- Sub-module pwrseq_timer holds the timeout counter. Its width is $clog2(TIMEOUT_CYCLES+1). Ports: clear, enable, expired. It is instantiated only under PWRSEQ_TIMEOUT_EN.

## Test plan
- Reset then request P0 (REQ_STATE=00), PHYSTATUS pulsed 5 cycles later → PWRDDWN=00 one cycle after accept; DONE with status 00, CUR_STATE=00.
- From P0, request P2 → DONE next cycle with status 01; PWRDDWN stays 00; no PHY activity.
- From P1, REQ_DETECT=1 with RXDET=1 at PHYSTATUS → RXDET_LOOPB high until the PHYSTATUS cycle; DONE with status 00, DET_PRESENT=1. Repeat from P0 → status 01.
- TIMEOUT_CYCLES=8 with PWRSEQ_TIMEOUT_EN defined, request P2 from P1, PHYSTATUS never asserted → DONE status 10 after 8 CHANGE cycles; PWRDDWN back to 10, CUR_STATE=10.
- PHYSTATUS asserted on the exact terminal-count cycle → status 00, CUR_STATE updated.
- RESET asserted while in CHANGE → outputs at reset values immediately; no DONE. New request after reset completes normally.
